exc_irq_ctrl: RTL and testbench
===============================

// Module: exc_irq_ctrl
// PURPOSE
//   Registered exception/interrupt sequencer for the LEGv8 pipeline. It sits beside the controller decoders.
//   - Latches rising edges on N_IRQ external interrupt lines and prioritises them against invalid-opcode faults.
//   - Drives Exc/EStatus with a request/acknowledge handshake and per-channel IRQ acknowledges.
//   - Holds state until the handler returns with ERET.
// PARAMETERS
//   N_IRQ      4   external interrupt channels, 1..8 (elaboration error outside range)
//   ESTATUS_W  4   EStatus width; fixed at 4, codes come from exc_pkg
// PORTS
//   clk          in   1      system clock, rising edge
//   reset        in   1      asynchronous, active-low reset
//   irq          in   N_IRQ  external IRQ levels, already synchronous to clk
//   not_an_instr in   1      decoder flag: current instruction invalid (1-cycle pulse per instr)
//   eret         in   1      decoder flag: ERET executing
//   exc_ack      in   1      pipeline has flushed and vectored to the handler
//   exc          out  1      exception request to pipeline
//   estatus      out  4      cause code of the request/handler in progress
//   irq_ack      out  N_IRQ  1-cycle one-hot acknowledge of the serviced channel
//   in_handler   out  1      high while in HANDLER state
//   double_fault out  1      sticky: invalid instruction while in HANDLER
// BEHAVIOUR
//   Reset (reset==0, async): state=IDLE, pending=0, irq_q=0. All outputs 0.
//   Edge capture: irq_q<=irq; pending[k] set when irq[k]&~irq_q[k]; cleared on its irq_ack.
//     Set and clear on the same cycle: set wins, so the new edge is kept pending.
//   Priority: not_an_instr > pending[0] > pending[1] > ... > pending[N_IRQ-1].
//   FSM (exc, estatus, in_handler registered; state encoding from exc_pkg):
//     IDLE    -> REQ      not_an_instr: estatus=EST_INVOP (4'b0010)
//             -> REQ      else any enabled pending: estatus={1'b1,k[2:0]} for winning k; sel<=k
//             -> IDLE     otherwise; exc=0, estatus=0
//     REQ     exc=1, estatus stable. On exc_ack: irq_ack[sel] pulses the same cycle (IRQ cause only),
//             pending[sel] cleared, -> HANDLER
//     HANDLER exc=0, in_handler=1, estatus held. New IRQ edges stay pending, none serviced.
//             eret -> IDLE, estatus cleared to 0 at the same edge.
//             not_an_instr -> double_fault<=1, stays in HANDLER, no new request.
//   Latency:
//     not_an_instr at edge t -> exc=1 after t.
//     irq rise sampled at edge t -> pending after t -> exc=1 after t+1.
//     exc_ack seen -> irq_ack pulse that cycle -> in_handler=1 next cycle.
//   eret outside HANDLER is ignored. exc_ack outside REQ is ignored.
//   Back-to-back: returning to IDLE with pending bits set re-enters REQ at the next edge.
//   Reset mid-REQ/HANDLER aborts immediately. Pending edges are lost. double_fault clears only on reset.
// CONFIGURATION
//   IRQ_MASK_EN defined:
//     Adds ports mask_we (in,1) and mask_wdata (in,N_IRQ).
//     mask register resets to all-ones. mask<=mask_wdata when mask_we.
//     Only pending&mask competes for priority. Masked edges still latch and fire when unmasked.
//   IRQ_MASK_EN undefined: no mask ports; all channels always enabled.
// STRUCTURE
//   exc_pkg (shared with controller/maindec):
//     - exc_state_t enum {IDLE,REQ,HANDLER}
//     - EST_NONE=4'b0000, EST_INVOP=4'b0010, EST_IRQ_BASE=4'b1000
//     - EST_DFAULT=4'b0011 reserved
//   Sub-module irq_prio_enc: N_IRQ request vector -> valid + binary index (lowest index wins).
//   FSM, pending/edge registers and outputs in exc_irq_ctrl.
// TESTING
//   1 Reset mid-REQ:
//       irq[2] rise; reset=0 while exc=1 -> all outputs 0 the same cycle.
//       After release pending=0, exc stays 0.
//   2 Single IRQ:
//       irq[1] 0->1 at edge t -> exc=1, estatus=4'b1001 after t+1.
//       exc_ack -> irq_ack=4'b0010 for 1 cycle, in_handler=1.
//       eret -> IDLE, estatus=0.
//   3 Priority:
//       not_an_instr and irq[0] rise same cycle -> estatus=4'b0010 first.
//       After eret -> exc=1, estatus=4'b1000.
//   4 Simultaneous IRQs:
//       irq=4'b1100 rising together -> service channel 2 (4'b1010), then 3 (4'b1011) back-to-back.
//       Each channel gets exactly one irq_ack pulse.
//   5 Handler faults:
//       In HANDLER: not_an_instr -> double_fault=1 sticky, exc stays 0.
//       irq[3] rise during HANDLER is serviced only after eret.
//   6 IRQ_MASK_EN build:
//       mask_wdata=4'b1110; irq[0] rise -> no exc.
//       Then mask 4'b1111 -> exc=1, estatus=4'b1000 within 1 cycle of the mask write.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared exception/interrupt types and cause codes for the LEGv8 controller slice.
package exc_pkg;

    localparam int unsigned EST_W     = 4;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned N_IRQ_MAX = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HANDLER = 2'd2
    } exc_state_t;

    localparam logic [EST_W-1:0] EST_NONE     = 4'b0000;
    localparam logic [EST_W-1:0] EST_INVOP    = 4'b0010;
    localparam logic [EST_W-1:0] EST_DFAULT   = 4'b0011;
    localparam logic [EST_W-1:0] EST_IRQ_BASE = 4'b1000;

    // Cause latched at request time; idx is meaningful only when is_irq is set.
    typedef struct packed {
        logic             is_irq;
        logic [IDX_W-1:0] idx;
    } exc_sel_t;

    function automatic logic [EST_W-1:0] irq_cause(input logic [IDX_W-1:0] idx);
        return EST_IRQ_BASE | EST_W'(idx);
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module irq_prio_enc
    import exc_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]     req,
    output logic             valid_c,
    output logic [IDX_W-1:0] idx_c
);

    always_comb begin
        valid_c = 1'b0;
        idx_c   = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (req[k] && !valid_c) begin
                valid_c = 1'b1;
                idx_c   = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/exc_irq_ctrl.sv
// Exception/interrupt sequencer: IRQ edge capture, cause priority, exc/ack handshake, ERET return.
// Optional per-channel interrupt mask when IRQ_MASK_EN is defined.
module exc_irq_ctrl
    import exc_pkg::*;
#(
    parameter int unsigned N_IRQ     = 4,
    parameter int unsigned ESTATUS_W = EST_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_IRQ-1:0]     irq,
    input  logic                 not_an_instr,
    input  logic                 eret,
    input  logic                 exc_ack,
`ifdef IRQ_MASK_EN
    input  logic                 mask_we,
    input  logic [N_IRQ-1:0]     mask_wdata,
`endif
    output logic                 exc,
    output logic [ESTATUS_W-1:0] estatus,
    output logic [N_IRQ-1:0]     irq_ack,
    output logic                 in_handler,
    output logic                 double_fault
);

    if (N_IRQ < 1 || N_IRQ > N_IRQ_MAX) begin : g_bad_n_irq
        $error("exc_irq_ctrl: N_IRQ must be in 1..8");
    end
    if (ESTATUS_W != EST_W) begin : g_bad_estatus_w
        $error("exc_irq_ctrl: ESTATUS_W must be 4");
    end

    exc_state_t           state, state_nx;
    exc_sel_t             sel, sel_nx;
    logic [EST_W-1:0]     estatus_nx;
    logic                 dfault_nx;
    logic [N_IRQ-1:0]     irq_q, pending, enabled;
    logic                 prio_valid;
    logic [IDX_W-1:0]     prio_idx;

`ifdef IRQ_MASK_EN
    logic [N_IRQ-1:0]     mask;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       mask <= '1;
        else if (mask_we) mask <= mask_wdata;
    end

    assign enabled = pending & mask;
`else
    assign enabled = pending;
`endif

    irq_prio_enc #(.N(N_IRQ)) u_prio (
        .req     (enabled),
        .valid_c (prio_valid),
        .idx_c   (prio_idx)
    );

    // Acknowledge is combinational so the channel sees it in the exc_ack cycle.
    always_comb begin
        irq_ack = '0;
        if (state == REQ && exc_ack && sel.is_irq) irq_ack = N_IRQ'(1) << sel.idx;
    end

    always_comb begin
        state_nx   = state;
        sel_nx     = sel;
        estatus_nx = estatus;
        dfault_nx  = double_fault;
        case (state)
            IDLE: begin
                if (not_an_instr) begin
                    state_nx   = REQ;
                    estatus_nx = EST_INVOP;
                    sel_nx     = '{is_irq: 1'b0, idx: '0};
                end else if (prio_valid) begin
                    state_nx   = REQ;
                    estatus_nx = irq_cause(prio_idx);
                    sel_nx     = '{is_irq: 1'b1, idx: prio_idx};
                end else begin
                    estatus_nx = EST_NONE;
                end
            end
            REQ: begin
                if (exc_ack) state_nx = HANDLER;
            end
            HANDLER: begin
                if (not_an_instr) dfault_nx = 1'b1;
                if (eret) begin
                    state_nx   = IDLE;
                    estatus_nx = EST_NONE;
                end
            end
            default: begin
                state_nx   = IDLE;
                estatus_nx = EST_NONE;
            end
        endcase
    end

    // New edges win over a same-cycle acknowledge of the same channel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            sel          <= '0;
            irq_q        <= '0;
            pending      <= '0;
            exc          <= 1'b0;
            estatus      <= '0;
            in_handler   <= 1'b0;
            double_fault <= 1'b0;
        end else begin
            state        <= state_nx;
            sel          <= sel_nx;
            irq_q        <= irq;
            pending      <= (pending & ~irq_ack) | (irq & ~irq_q);
            exc          <= (state_nx == REQ);
            estatus      <= estatus_nx;
            in_handler   <= (state_nx == HANDLER);
            double_fault <= dfault_nx;
        end
    end

endmodule

// File: tb/tb_exc_irq_ctrl.sv
// Directed self-checking bench for exc_irq_ctrl (mask scenario only when IRQ_MASK_EN is defined).
`timescale 1ns/1ps
module tb_exc_irq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq;
    logic       not_an_instr;
    logic       eret;
    logic       exc_ack;
`ifdef IRQ_MASK_EN
    logic       mask_we;
    logic [3:0] mask_wdata;
`endif
    logic       exc;
    logic [3:0] estatus;
    logic [3:0] irq_ack;
    logic       in_handler;
    logic       double_fault;

    int n_cmp = 0;
    int n_err = 0;
    int ack_cnt [4];
    int snap2, snap3;

    exc_irq_ctrl #(.N_IRQ(4), .ESTATUS_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .irq          (irq),
        .not_an_instr (not_an_instr),
        .eret         (eret),
        .exc_ack      (exc_ack),
`ifdef IRQ_MASK_EN
        .mask_we      (mask_we),
        .mask_wdata   (mask_wdata),
`endif
        .exc          (exc),
        .estatus      (estatus),
        .irq_ack      (irq_ack),
        .in_handler   (in_handler),
        .double_fault (double_fault)
    );

    always #5 clk = ~clk;

    initial for (int k = 0; k < 4; k++) ack_cnt[k] = 0;

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) if (irq_ack[k] === 1'b1) ack_cnt[k] = ack_cnt[k] + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b0;
        irq          = '0;
        not_an_instr = 1'b0;
        eret         = 1'b0;
        exc_ack      = 1'b0;
`ifdef IRQ_MASK_EN
        mask_we      = 1'b0;
        mask_wdata   = '0;
`endif
        tick(); tick();
        check("rst_exc",     32'(exc), 0);
        check("rst_estatus", 32'(estatus), 0);
        check("rst_irq_ack", 32'(irq_ack), 0);
        check("rst_in_hdl",  32'(in_handler), 0);
        check("rst_dfault",  32'(double_fault), 0);
        reset = 1'b1;
        tick();

        // Reset mid-REQ
        irq = 4'b0100;
        tick();
        check("t1_exc_lat", 32'(exc), 0);
        tick();
        check("t1_exc_req", 32'(exc), 1);
        check("t1_est_req", 32'(estatus), 32'h a);
        reset = 1'b0;
        #1;
        check("t1_async_exc", 32'(exc), 0);
        check("t1_async_est", 32'(estatus), 0);
        irq = '0;
        tick();
        reset = 1'b1;
        tick(); tick(); tick();
        check("t1_post_exc", 32'(exc), 0);

        // Single IRQ on channel 1
        irq = 4'b0010;
        tick();
        check("t2_exc_lat", 32'(exc), 0);
        tick();
        check("t2_exc", 32'(exc), 1);
        check("t2_est", 32'(estatus), 32'h9);
        exc_ack = 1'b1;
        #1;
        check("t2_irq_ack", 32'(irq_ack), 32'h2);
        tick();
        exc_ack = 1'b0;
        #1;
        check("t2_ack_once", 32'(irq_ack), 0);
        check("t2_in_hdl",   32'(in_handler), 1);
        check("t2_exc_low",  32'(exc), 0);
        check("t2_est_hold", 32'(estatus), 32'h9);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        irq  = '0;
        check("t2_eret_hdl", 32'(in_handler), 0);
        check("t2_eret_est", 32'(estatus), 0);

        // exc_ack outside REQ is ignored
        exc_ack = 1'b1;
        tick();
        exc_ack = 1'b0;
        check("t2_stray_ack", 32'(in_handler), 0);

        // Invalid opcode beats a simultaneous IRQ edge
        irq          = 4'b0001;
        not_an_instr = 1'b1;
        tick();
        not_an_instr = 1'b0;
        check("t3_exc", 32'(exc), 1);
        check("t3_est_invop", 32'(estatus), 32'h2);
        exc_ack = 1'b1;
        #1;
        check("t3_no_irq_ack", 32'(irq_ack), 0);
        tick();
        exc_ack = 1'b0;
        eret    = 1'b1;
        tick();
        eret = 1'b0;
        check("t3_idle_exc", 32'(exc), 0);
        tick();
        check("t3_b2b_exc", 32'(exc), 1);
        check("t3_b2b_est", 32'(estatus), 32'h8);
        exc_ack = 1'b1;
        #1;
        check("t3_irq_ack", 32'(irq_ack), 32'h1);
        tick();
        exc_ack = 1'b0;
        eret    = 1'b1;
        tick();
        eret = 1'b0;
        irq  = '0;
        tick();

        // Simultaneous IRQs on channels 2 and 3
        snap2 = ack_cnt[2];
        snap3 = ack_cnt[3];
        irq = 4'b1100;
        tick(); tick();
        check("t4_exc_a", 32'(exc), 1);
        check("t4_est_a", 32'(estatus), 32'ha);
        exc_ack = 1'b1;
        #1;
        check("t4_ack_a", 32'(irq_ack), 32'h4);
        tick();
        exc_ack = 1'b0;
        eret    = 1'b1;
        tick();
        eret = 1'b0;
        check("t4_idle", 32'(exc), 0);
        tick();
        check("t4_exc_b", 32'(exc), 1);
        check("t4_est_b", 32'(estatus), 32'hb);
        exc_ack = 1'b1;
        #1;
        check("t4_ack_b", 32'(irq_ack), 32'h8);
        tick();
        exc_ack = 1'b0;
        eret    = 1'b1;
        tick();
        eret = 1'b0;
        tick(); tick();
        check("t4_drained", 32'(exc), 0);
        check("t4_cnt2", 32'(ack_cnt[2] - snap2), 1);
        check("t4_cnt3", 32'(ack_cnt[3] - snap3), 1);
        irq = '0;
        tick();

        // Faults and IRQs while in HANDLER
        not_an_instr = 1'b1;
        tick();
        not_an_instr = 1'b0;
        exc_ack      = 1'b1;
        tick();
        exc_ack = 1'b0;
        check("t5_in_hdl", 32'(in_handler), 1);
        not_an_instr = 1'b1;
        irq          = 4'b1000;
        tick();
        not_an_instr = 1'b0;
        check("t5_dfault",  32'(double_fault), 1);
        check("t5_exc_low", 32'(exc), 0);
        check("t5_est",     32'(estatus), 32'h2);
        tick(); tick();
        check("t5_irq_held", 32'(exc), 0);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        check("t5_idle", 32'(exc), 0);
        tick();
        check("t5_irq3_exc", 32'(exc), 1);
        check("t5_irq3_est", 32'(estatus), 32'hb);
        exc_ack = 1'b1;
        tick();
        exc_ack = 1'b0;
        eret    = 1'b1;
        tick();
        eret = 1'b0;
        irq  = '0;
        check("t5_dfault_sticky", 32'(double_fault), 1);
        tick();

`ifdef IRQ_MASK_EN
        // Masked edge latches and fires once unmasked
        mask_we    = 1'b1;
        mask_wdata = 4'b1110;
        tick();
        mask_we = 1'b0;
        irq     = 4'b0001;
        tick(); tick(); tick();
        check("t6_masked", 32'(exc), 0);
        mask_we    = 1'b1;
        mask_wdata = 4'b1111;
        tick();
        mask_we = 1'b0;
        tick();
        check("t6_unmask_exc", 32'(exc), 1);
        check("t6_unmask_est", 32'(estatus), 32'h8);
`endif

        reset = 1'b0;
        #1;
        check("end_dfault_rst", 32'(double_fault), 0);
        check("end_exc_rst", 32'(exc), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
